// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard control bundle between the 5-stage core (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W    = 5,
    parameter int NUM_STALL_SRC = 2,
    parameter int CNT_W         = 32
);
    logic                     branch_enable_i;
    logic [REG_ADDR_W-1:0]    id_rs1_i;
    logic [REG_ADDR_W-1:0]    id_rs2_i;
    logic                     id_rs1_read_i;
    logic                     id_rs2_read_i;
    logic [REG_ADDR_W-1:0]    ex_rd_i;
    logic                     ex_mem_read_i;
    logic [NUM_STALL_SRC-1:0] ext_stall_req_i;
    logic                     stall_pc_o;
    logic                     stall_ifid_o;
    logic                     stall_idex_o;
    logic                     flush_ifid_o;
    logic                     flush_idex_o;
    logic                     stall_timeout_o;
    logic [CNT_W-1:0]         stall_cycle_cnt_o;
    logic [CNT_W-1:0]         flush_cycle_cnt_o;

    modport master (
        output branch_enable_i, id_rs1_i, id_rs2_i, id_rs1_read_i, id_rs2_read_i,
               ex_rd_i, ex_mem_read_i, ext_stall_req_i,
        input  stall_pc_o, stall_ifid_o, stall_idex_o, flush_ifid_o, flush_idex_o,
               stall_timeout_o, stall_cycle_cnt_o, flush_cycle_cnt_o
    );

    modport slave (
        input  branch_enable_i, id_rs1_i, id_rs2_i, id_rs1_read_i, id_rs2_read_i,
               ex_rd_i, ex_mem_read_i, ext_stall_req_i,
        output stall_pc_o, stall_ifid_o, stall_idex_o, flush_ifid_o, flush_idex_o,
               stall_timeout_o, stall_cycle_cnt_o, flush_cycle_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: branch flush window, load-use interlock, external stalls with watchdog.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | no multi-cycle hazard in progress; branch / load-use resolved combinationally
// FLUSH | IF/ID flush window after a branch, flush_cnt cycles remaining
// EXT   | external requester holding the pipe; branches latched into pend_br
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W    = 5,
    parameter int NUM_STALL_SRC = 2,
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 255,
    parameter int CNT_W         = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int RUN_W  = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [RUN_W-1:0]  RUN_LIMIT    = RUN_W'(STALL_TIMEOUT);
    localparam bit                MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_EXT} state_t;

    state_t            state;
    logic [FCNT_W-1:0] flush_cnt;
    logic [RUN_W-1:0]  stall_run;
    logic [RUN_W-1:0]  run_nxt;
    logic              pend_br;
    logic              timeout_q;

    logic ext, br, br_eff, lu;
    logic stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex;

    assign ext    = |hz.ext_stall_req_i;
    assign br     = hz.branch_enable_i;
    // pend_br is only ever set in EXT/FLUSH, so it can be folded in unconditionally
    assign br_eff = br | pend_br;
    assign lu     = hz.ex_mem_read_i & (hz.ex_rd_i != '0) &
                    ((hz.id_rs1_read_i & (hz.id_rs1_i == hz.ex_rd_i)) |
                     (hz.id_rs2_read_i & (hz.id_rs2_i == hz.ex_rd_i)));
    assign run_nxt = (stall_run == RUN_LIMIT) ? stall_run : stall_run + 1'b1;

    always_comb begin
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        stall_idex = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (rst_i) begin
            case (state)
                ST_FLUSH: begin
                    flush_ifid = 1'b1;
                    if (ext) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        stall_idex = 1'b1;
                    end else if (br_eff) begin
                        flush_idex = 1'b1;
                    end
                end
                default: begin
                    if (ext) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        stall_idex = 1'b1;
                    end else if (br_eff) begin
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else if (lu) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            stall_run <= '0;
            pend_br   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ext) begin
                        state     <= ST_EXT;
                        pend_br   <= br;
                        stall_run <= RUN_W'(1);
                        timeout_q <= timeout_q | (RUN_W'(1) == RUN_LIMIT);
                    end else if (br && MULTI_FLUSH) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_RELOAD;
                    end
                end
                ST_EXT: begin
                    if (ext) begin
                        pend_br   <= pend_br | br;
                        stall_run <= run_nxt;
                        timeout_q <= timeout_q | (run_nxt == RUN_LIMIT);
                    end else begin
                        pend_br   <= 1'b0;
                        stall_run <= '0;
                        if (br_eff && MULTI_FLUSH) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FLUSH_RELOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    // a branch arriving under an external stall is held until the stall drops
                    if (ext) begin
                        pend_br <= pend_br | br;
                    end else if (br_eff) begin
                        pend_br   <= 1'b0;
                        flush_cnt <= FLUSH_RELOAD;
                    end else if (flush_cnt <= FCNT_W'(1)) begin
                        state <= ST_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign hz.stall_pc_o      = stall_pc;
    assign hz.stall_ifid_o    = stall_ifid;
    assign hz.stall_idex_o    = stall_idex;
    assign hz.flush_ifid_o    = flush_ifid;
    assign hz.flush_idex_o    = flush_idex;
    assign hz.stall_timeout_o = rst_i & timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cyc;
    logic [CNT_W-1:0] flush_cyc;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cyc <= '0;
            flush_cyc <= '0;
        end else begin
            if (stall_pc && (stall_cyc != '1)) stall_cyc <= stall_cyc + 1'b1;
            if (flush_ifid && (flush_cyc != '1)) flush_cyc <= flush_cyc + 1'b1;
        end
    end

    assign hz.stall_cycle_cnt_o = rst_i ? stall_cyc : '0;
    assign hz.flush_cycle_cnt_o = rst_i ? flush_cyc : '0;
`else
    assign hz.stall_cycle_cnt_o = '0;
    assign hz.flush_cycle_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FLUSH_CYCLES=3, STALL_TIMEOUT=8.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .NUM_STALL_SRC(2), .CNT_W(32)) hz();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(5), .NUM_STALL_SRC(2), .FLUSH_CYCLES(3), .STALL_TIMEOUT(8), .CNT_W(32)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .hz(hz)
    );

    // {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex}
    logic [4:0] ctl;
    assign ctl = {hz.stall_pc_o, hz.stall_ifid_o, hz.stall_idex_o, hz.flush_ifid_o, hz.flush_idex_o};

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] EXP_FLUSH_CNT = 32'd3;
    localparam logic [31:0] EXP_STALL_CNT = 32'd1;
`else
    localparam logic [31:0] EXP_FLUSH_CNT = 32'd0;
    localparam logic [31:0] EXP_STALL_CNT = 32'd0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [4:0] exp_ctl);
        @(negedge clk);
        chk(tag, 64'(ctl), 64'(exp_ctl));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.branch_enable_i = 1'b0;
        hz.id_rs1_i        = '0;
        hz.id_rs2_i        = '0;
        hz.id_rs1_read_i   = 1'b0;
        hz.id_rs2_read_i   = 1'b0;
        hz.ex_rd_i         = '0;
        hz.ex_mem_read_i   = 1'b0;
        hz.ext_stall_req_i = '0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        hz.branch_enable_i = 1'b1;
        @(negedge clk);
        chk("rst_ctl", 64'(ctl), 64'd0);
        chk("rst_timeout", 64'(hz.stall_timeout_o), 64'd0);
        chk("rst_scnt", 64'(hz.stall_cycle_cnt_o), 64'd0);
        hz.branch_enable_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("idle", 5'b00000);

        // branch with a 3-cycle flush window
        hz.branch_enable_i = 1'b1;
        step("br_c1", 5'b00011);
        hz.branch_enable_i = 1'b0;
        step("br_c2", 5'b00010);
        step("br_c3", 5'b00010);
        step("br_done", 5'b00000);

        // load-use on rs2
        hz.ex_mem_read_i = 1'b1; hz.ex_rd_i = 5'd5; hz.id_rs2_i = 5'd5; hz.id_rs2_read_i = 1'b1;
        step("lu_rs2", 5'b11001);
        clear_inputs();
        @(negedge clk);
        chk("perf_flush", 64'(hz.flush_cycle_cnt_o), 64'(EXP_FLUSH_CNT));
        chk("perf_stall", 64'(hz.stall_cycle_cnt_o), 64'(EXP_STALL_CNT));
        step("lu_clear", 5'b00000);

        // x0 never interlocks
        hz.ex_mem_read_i = 1'b1; hz.ex_rd_i = 5'd0; hz.id_rs2_i = 5'd0; hz.id_rs2_read_i = 1'b1;
        step("lu_x0", 5'b00000);
        // matching register but not read
        hz.ex_rd_i = 5'd9; hz.id_rs1_i = 5'd9; hz.id_rs1_read_i = 1'b0; hz.id_rs2_read_i = 1'b0;
        step("lu_noread", 5'b00000);
        hz.id_rs1_read_i = 1'b1;
        step("lu_rs1", 5'b11001);
        hz.ex_mem_read_i = 1'b0;
        step("lu_noload", 5'b00000);

        // branch beats load-use; load-use ignored inside the flush window
        hz.ex_mem_read_i = 1'b1; hz.branch_enable_i = 1'b1;
        step("br_lu", 5'b00011);
        hz.branch_enable_i = 1'b0;
        step("flush_ign_lu1", 5'b00010);
        step("flush_ign_lu2", 5'b00010);
        clear_inputs();
        step("br_lu_done", 5'b00000);

        // external stall 4 cycles with a branch pulse in cycle 2
        hz.ext_stall_req_i = 2'b10;
        step("ext_c1", 5'b11100);
        hz.branch_enable_i = 1'b1;
        step("ext_c2", 5'b11100);
        hz.branch_enable_i = 1'b0;
        step("ext_c3", 5'b11100);
        step("ext_c4", 5'b11100);
        hz.ext_stall_req_i = 2'b00;
        step("ext_release", 5'b00011);
        chk("ext_no_timeout", 64'(hz.stall_timeout_o), 64'd0);
        step("ext_flush2", 5'b00010);
        step("ext_flush3", 5'b00010);
        step("ext_done", 5'b00000);

        // watchdog: ext held 10 cycles, timeout after the 8th stall edge
        hz.ext_stall_req_i = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk($sformatf("wd_ctl_%0d", i), 64'(ctl), 64'b11100);
            chk($sformatf("wd_to_%0d", i), 64'(hz.stall_timeout_o), (i >= 9) ? 64'd1 : 64'd0);
            @(posedge clk); #1;
        end
        hz.ext_stall_req_i = 2'b00;
        step("wd_release", 5'b00000);
        @(negedge clk);
        chk("wd_sticky", 64'(hz.stall_timeout_o), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("wd_rst_comb", 64'(hz.stall_timeout_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("wd_rst_clr", 64'(hz.stall_timeout_o), 64'd0);
        @(posedge clk); #1;

        // reset inside the flush window aborts it
        hz.branch_enable_i = 1'b1;
        step("rf_br", 5'b00011);
        hz.branch_enable_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rf_rst_ctl", 64'(ctl), 64'd0);
        chk("rf_rst_fcnt", 64'(hz.flush_cycle_cnt_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("rf_after1", 5'b00000);
        step("rf_after2", 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
